intersection_scheduler: RTL

- Sequences a two-road intersection: main road, side road and one pedestrian crossing.
- Shares the crossing between side-road vehicles and pedestrians. Main road gets green by default.
- Produces the green/yellow/red and walk/dontwalk lamp signals for both roads from one phase state machine.
- Sits above the lamp drivers. It is the only block that decides phase order and phase timing.

---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/intersection_scheduler_if.sv | 32 +++
 rtl/intersection_scheduler_phase_timer.sv | 36 +++
 rtl/intersection_scheduler.sv | 125 ++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encoding and default phase durations for the intersection scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    PED_WALK    = 3'd6,
    ALL_RED_P   = 3'd7
  } phase_e;

  localparam int unsigned CNT_W_DEF        = 8;
  localparam int unsigned MAIN_MIN_DEF     = 20;
  localparam int unsigned SIDE_GREEN_T_DEF = 10;
  localparam int unsigned YELLOW_T_DEF     = 4;
  localparam int unsigned ALLRED_T_DEF     = 2;
  localparam int unsigned WALK_T_DEF       = 8;

  // Cycle count of a phase; MAIN_GREEN returns its minimum, it may be held longer.
  function automatic int unsigned duration_of(
    phase_e      p,
    int unsigned main_min = MAIN_MIN_DEF,
    int unsigned side_g   = SIDE_GREEN_T_DEF,
    int unsigned yellow   = YELLOW_T_DEF,
    int unsigned allred   = ALLRED_T_DEF,
    int unsigned walk     = WALK_T_DEF
  );
    int unsigned d;
    d = main_min;
    case (p)
      MAIN_GREEN:                        d = main_min;
      MAIN_YELLOW, SIDE_YELLOW:          d = yellow;
      ALL_RED_A, ALL_RED_B, ALL_RED_P:   d = allred;
      SIDE_GREEN:                        d = side_g;
      PED_WALK:                          d = walk;
      default:                           d = main_min;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// Request inputs and lamp outputs of the intersection scheduler.
// walk_remaining exists only when PED_COUNTDOWN_EN is defined.
interface intersection_scheduler_if #(parameter int unsigned CNT_W = 8);
  logic       side_req;
  logic       ped_req;
  logic       main_g, main_y, main_r;
  logic       side_g, side_y, side_r;
  logic       walk, dontwalk;
  logic       ped_pending;
  logic [2:0] phase;
`ifdef PED_COUNTDOWN_EN
  logic [CNT_W-1:0] walk_remaining;
`endif

  modport master (
    output side_req, ped_req,
    input  main_g, main_y, main_r, side_g, side_y, side_r,
    input  walk, dontwalk, ped_pending, phase
`ifdef PED_COUNTDOWN_EN
    , input walk_remaining
`endif
  );

  modport slave (
    input  side_req, ped_req,
    output main_g, main_y, main_r, side_g, side_y, side_r,
    output walk, dontwalk, ped_pending, phase
`ifdef PED_COUNTDOWN_EN
    , output walk_remaining
`endif
  );
endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// Loadable saturating down-counter timing the current phase.
module phase_timer #(
  parameter int unsigned    CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/intersection_scheduler.sv
// Phase sequencer for a main road, side road and pedestrian crossing.
// Optional macro PED_COUNTDOWN_EN adds the walk_remaining countdown output.
//
// state       | meaning
// MAIN_GREEN  | main road green, held until min time elapsed and a request is seen
// MAIN_YELLOW | main road yellow
// ALL_RED_A   | clearance after main; pedestrians win over side road
// SIDE_GREEN  | side road green, fixed length
// SIDE_YELLOW | side road yellow
// ALL_RED_B   | clearance back to main
// PED_WALK    | walk lamp on, both roads red
// ALL_RED_P   | clearance after walk; side road served next if still requesting
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned MAIN_MIN     = MAIN_MIN_DEF,
  parameter int unsigned SIDE_GREEN_T = SIDE_GREEN_T_DEF,
  parameter int unsigned YELLOW_T     = YELLOW_T_DEF,
  parameter int unsigned ALLRED_T     = ALLRED_T_DEF,
  parameter int unsigned WALK_T       = WALK_T_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  intersection_scheduler_if.slave   bus
);

  phase_e           state_q, state_d;
  logic             ped_pending_q, ped_pending_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;
  logic [CNT_W-1:0] timer_cnt;
  logic             timer_zero;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(MAIN_MIN - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_load_val),
    .count    (timer_cnt),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d = state_q;
    if (timer_zero) begin
      case (state_q)
        MAIN_GREEN:  if (bus.side_req || ped_pending_q) state_d = MAIN_YELLOW;
        MAIN_YELLOW: state_d = ALL_RED_A;
        ALL_RED_A:   state_d = ped_pending_q ? PED_WALK : SIDE_GREEN;
        SIDE_GREEN:  state_d = SIDE_YELLOW;
        SIDE_YELLOW: state_d = ALL_RED_B;
        ALL_RED_B:   state_d = MAIN_GREEN;
        PED_WALK:    state_d = ALL_RED_P;
        ALL_RED_P:   state_d = bus.side_req ? SIDE_GREEN : MAIN_GREEN;
        default:     state_d = MAIN_GREEN;
      endcase
    end

    timer_load     = (state_d != state_q);
    timer_load_val = CNT_W'(duration_of(state_d, MAIN_MIN, SIDE_GREEN_T,
                                        YELLOW_T, ALLRED_T, WALK_T) - 1);

    // Entering the walk phase clears the latch even if the button is pressed on that edge.
    ped_pending_d = ped_pending_q;
    if (state_d == PED_WALK && state_q != PED_WALK) begin
      ped_pending_d = 1'b0;
    end else if (bus.ped_req && state_q != PED_WALK) begin
      ped_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= MAIN_GREEN;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  logic main_g, main_y, main_r, side_g, side_y, side_r, walk, dontwalk;

  always_comb begin
    main_g   = 1'b0;
    main_y   = 1'b0;
    main_r   = 1'b1;
    side_g   = 1'b0;
    side_y   = 1'b0;
    side_r   = 1'b1;
    walk     = 1'b0;
    dontwalk = 1'b1;
    case (state_q)
      MAIN_GREEN:  begin main_g = 1'b1; main_r = 1'b0; end
      MAIN_YELLOW: begin main_y = 1'b1; main_r = 1'b0; end
      SIDE_GREEN:  begin side_g = 1'b1; side_r = 1'b0; end
      SIDE_YELLOW: begin side_y = 1'b1; side_r = 1'b0; end
      PED_WALK:    begin walk   = 1'b1; dontwalk = 1'b0; end
      default:     ;
    endcase
  end

  assign bus.main_g      = main_g;
  assign bus.main_y      = main_y;
  assign bus.main_r      = main_r;
  assign bus.side_g      = side_g;
  assign bus.side_y      = side_y;
  assign bus.side_r      = side_r;
  assign bus.walk        = walk;
  assign bus.dontwalk    = dontwalk;
  assign bus.ped_pending = ped_pending_q;
  assign bus.phase       = state_q;

`ifdef PED_COUNTDOWN_EN
  assign bus.walk_remaining = (state_q == PED_WALK) ? timer_cnt + CNT_W'(1) : '0;
`else
  logic unused_timer_cnt;
  assign unused_timer_cnt = ^timer_cnt;
`endif

endmodule
